// File: rtl/prco_fetch_dec_regs.sv
// prco_fetch_dec_regs: fetch/decode/register-write front end with zero-initialised local memory
module prco_fetch_dec_regs (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_p_valid,
    input  logic [15:0] i_pc,
    input  logic        i_p_block,
    output logic        q_p_stalled,
    output logic        q_p_cp,
    input  logic        i_mem_we,
    input  logic [7:0]  i_mem_addr,
    input  logic [15:0] i_mem_dina,
    output logic [15:0] q_mem_douta,
    output logic [5:0]  q_op,
    output logic [2:0]  q_seld,
    output logic [2:0]  q_sela,
    output logic [15:0] q_imm8,
    output logic        q_reg_we,
    input  logic [2:0]  i_rd_sela,
    input  logic [2:0]  i_rd_selb,
    output logic [15:0] q_rd_data,
    output logic [15:0] q_rd_datb
);
    typedef enum logic [1:0] {IDLE, FETCH, DECODE, WRITE} state_t;
    state_t state, state_nx;
    logic [15:0] mem [256];
    logic [15:0] regs [8];
    logic [15:0] fetch_word;
    logic accept;
    logic unused_pc_hi;
    initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    assign unused_pc_hi = ^i_pc[15:8];
    assign accept = state == IDLE && i_p_valid;
    assign q_p_stalled = state != IDLE;
    assign q_rd_data = regs[i_rd_sela];
    assign q_rd_datb = regs[i_rd_selb];
    always_ff @(posedge i_clk) begin
        if (i_mem_we) mem[i_mem_addr] <= i_mem_dina;
        if (accept) fetch_word <= mem[i_pc[7:0]];
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE   ? (i_p_valid ? FETCH : IDLE) :
                   state == FETCH  ? DECODE :
                   state == DECODE ? (i_p_block ? DECODE : WRITE) : IDLE;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_mem_douta <= '0;
            q_op <= '0;
            q_seld <= '0;
            q_sela <= '0;
            q_imm8 <= '0;
            q_reg_we <= 1'b0;
            q_p_cp <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            q_p_cp <= state == WRITE;
            if (state == FETCH) q_mem_douta <= fetch_word;
            if (state == DECODE && !i_p_block) begin
                q_op <= {1'b0, q_mem_douta[15:11]};
                q_seld <= q_mem_douta[10:8];
                q_sela <= q_mem_douta[7:5];
                q_imm8 <= {8'h00, q_mem_douta[7:0]};
                q_reg_we <= q_mem_douta[15:11] == 5'd1 || q_mem_douta[15:11] == 5'd2;
            end
            if (state == WRITE && q_reg_we) regs[q_seld] <= q_op == 6'h01 ? q_imm8 : regs[q_sela];
        end
    end
endmodule

// File: tb/tb_prco_fetch_dec_regs.sv
// tb_prco_fetch_dec_regs: random instruction stream against a reference model, completions checked by a scoreboard monitor
module tb_prco_fetch_dec_regs;
    logic i_clk = 0, i_reset = 1, i_p_valid = 0, i_p_block = 0, i_mem_we = 0;
    logic [15:0] i_pc = 0, i_mem_dina = 0;
    logic [7:0] i_mem_addr = 0;
    logic [2:0] i_rd_sela = 0, i_rd_selb = 0;
    logic q_p_stalled, q_p_cp, q_reg_we;
    logic [15:0] q_mem_douta, q_imm8, q_rd_data, q_rd_datb;
    logic [5:0] q_op;
    logic [2:0] q_seld, q_sela;
    typedef struct packed {
        logic [5:0] op;
        logic [2:0] seld;
        logic [2:0] sela;
        logic [15:0] imm8;
        logic we;
        logic [7:0][15:0] regs;
    } exp_t;
    exp_t sb[$];
    logic [15:0] ref_mem [256];
    logic [15:0] ref_regs [8];
    int total = 0, bad = 0;

    prco_fetch_dec_regs dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_p_valid(i_p_valid), .i_pc(i_pc), .i_p_block(i_p_block),
        .q_p_stalled(q_p_stalled), .q_p_cp(q_p_cp), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr),
        .i_mem_dina(i_mem_dina), .q_mem_douta(q_mem_douta), .q_op(q_op), .q_seld(q_seld), .q_sela(q_sela),
        .q_imm8(q_imm8), .q_reg_we(q_reg_we), .i_rd_sela(i_rd_sela), .i_rd_selb(i_rd_selb),
        .q_rd_data(q_rd_data), .q_rd_datb(q_rd_datb)
    );

    always #10 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, req);
        end
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [15:0] d);
        i_mem_we = 1; i_mem_addr = a; i_mem_dina = d;
        ref_mem[a] = d;
        @(posedge i_clk); #3;
        i_mem_we = 0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [4:0] op;
        logic [10:0] rest;
        int sel;
        sel = $urandom_range(0, 3);
        rest = 11'($urandom);
        op = sel == 3 ? 5'($urandom) : 5'(sel);
        return {op, rest};
    endfunction

    // Starts at 3 ns after a rising edge with the block idle; returns likewise
    task automatic issue(input logic [15:0] pc, input int nb, input bit col, input logic [15:0] cdat);
        logic [15:0] w;
        logic [4:0] op;
        exp_t e;
        int k, stl;
        bit done;
        w = ref_mem[pc[7:0]];
        op = w[15:11];
        if (op == 5'd1) ref_regs[w[10:8]] = {8'h00, w[7:0]};
        else if (op == 5'd2) ref_regs[w[10:8]] = ref_regs[w[7:5]];
        e.op = {1'b0, op};
        e.seld = w[10:8];
        e.sela = w[7:5];
        e.imm8 = {8'h00, w[7:0]};
        e.we = op == 5'd1 || op == 5'd2;
        for (int r = 0; r < 8; r++) e.regs[r] = ref_regs[r];
        sb.push_back(e);
        i_p_valid = 1; i_pc = pc; i_p_block = nb > 0;
        if (col) begin
            i_mem_we = 1; i_mem_addr = pc[7:0]; i_mem_dina = cdat;
            ref_mem[pc[7:0]] = cdat;
        end
        k = 0; stl = 0; done = 0;
        while (!done && k < 50) begin
            @(posedge i_clk); #3;
            k++;
            i_p_valid = 0; i_mem_we = 0;
            if (k == nb + 2) i_p_block = 0;
            if (q_p_cp === 1'b1) done = 1;
            else stl += int'(q_p_stalled);
        end
        i_p_block = 0;
        check("cp_latency", 32'(k), 32'(nb + 4));
        check("stall_cycles", 32'(stl), 32'(nb + 3));
        check("stalled_in_cp", 32'(q_p_stalled), 32'd0);
        @(posedge i_clk); #3;
        check("cp_width", 32'(q_p_cp), 32'd0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk); #2;
            if (q_p_cp === 1'b1) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_cp at %0t: got 1, want 0", $time);
                end else begin
                    e = sb.pop_front();
                    check("op", 32'(q_op), 32'(e.op));
                    check("seld", 32'(q_seld), 32'(e.seld));
                    check("sela", 32'(q_sela), 32'(e.sela));
                    check("imm8", 32'(q_imm8), 32'(e.imm8));
                    check("reg_we", 32'(q_reg_we), 32'(e.we));
                    for (int r = 0; r < 8; r++) begin
                        i_rd_selb = 3'(r);
                        #1;
                        check($sformatf("R%0d", r), 32'(q_rd_datb), 32'(e.regs[r]));
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
        repeat (3) @(posedge i_clk);
        #3;
        check("rst_stalled", 32'(q_p_stalled), 32'd0);
        check("rst_cp", 32'(q_p_cp), 32'd0);
        check("rst_douta", 32'(q_mem_douta), 32'd0);
        check("rst_op", 32'(q_op), 32'd0);
        check("rst_seld", 32'(q_seld), 32'd0);
        check("rst_sela", 32'(q_sela), 32'd0);
        check("rst_imm8", 32'(q_imm8), 32'd0);
        check("rst_reg_we", 32'(q_reg_we), 32'd0);
        for (int r = 0; r < 8; r++) begin
            i_rd_sela = 3'(r);
            #1;
            check($sformatf("rst_R%0d", r), 32'(q_rd_data), 32'd0);
        end
        @(posedge i_clk); #3;
        i_reset = 0;
        mem_write(8'h00, 16'h0B5A);
        mem_write(8'h01, 16'h1560);
        mem_write(8'h02, 16'hF800);
        mem_write(8'h03, 16'h1360);
        // Abort an instruction in FETCH, keep requesting through the reset
        i_p_valid = 1; i_pc = 16'h0000;
        @(posedge i_clk); #3;
        check("abort_accepted", 32'(q_p_stalled), 32'd1);
        i_reset = 1;
        #1;
        check("abort_stalled", 32'(q_p_stalled), 32'd0);
        @(posedge i_clk); #3;
        check("abort_cp", 32'(q_p_cp), 32'd0);
        i_rd_sela = 3'd3;
        #1;
        check("abort_R3", 32'(q_rd_data), 32'd0);
        i_reset = 0;
        issue(16'h0000, 0, 0, 16'h0);
        issue(16'h0001, 0, 0, 16'h0);
        issue(16'h0002, 0, 0, 16'h0);
        issue(16'h0003, 0, 0, 16'h0);
        issue(16'h0000, 5, 0, 16'h0);
        issue(16'h0100, 0, 1, 16'h1560);
        issue(16'h0000, 0, 0, 16'h0);
        for (int a = 0; a < 16; a++) mem_write(8'(a), rand_instr());
        for (int n = 0; n < 40; n++) begin
            logic [15:0] pc;
            if ($urandom_range(0, 2) == 0) mem_write(8'($urandom_range(0, 15)), rand_instr());
            pc = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 15))};
            repeat ($urandom_range(0, 2)) begin
                @(posedge i_clk); #3;
            end
            issue(pc, $urandom_range(0, 3), $urandom_range(0, 3) == 0, rand_instr());
        end
        repeat (2) @(posedge i_clk);
        #3;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
